// File: rtl/hex_entry.sv
// hex_entry: debounced pushbutton hex-digit entry feeding a valid/ready committed word.
// Optional macro HEX_ENTRY_AUTO_COMMIT_EN: an enter that fills the buffer also commits it.
module hex_entry #(
  parameter int DIGITS    = 4,
  parameter int DB_CYCLES = 50000,
  parameter int DB_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        sw_digit,
  input  logic              key_enter_n,
  input  logic              key_commit_n,
  input  logic              key_clear_n,
  output logic [4*DIGITS-1:0] entry_value,
  output logic [3:0]        entry_count,
  output logic [4*DIGITS-1:0] out_value,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int VW = 4 * DIGITS;
  localparam logic [3:0] CNT_MAX = 4'(DIGITS);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_HOLD} state_t;

  // Key index: 0 = enter, 1 = commit, 2 = clear.
  logic [2:0] keys_n;
  logic [2:0] sync1_q, sync2_q, db_q, ev_q;
  logic [DB_W-1:0] dbc_q [3];

  assign keys_n = {key_clear_n, key_commit_n, key_enter_n};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      db_q    <= '1;
      ev_q    <= '0;
      for (int k = 0; k < 3; k++) dbc_q[k] <= '0;
    end else begin
      sync1_q <= keys_n;
      sync2_q <= sync1_q;
      ev_q    <= '0;
      for (int k = 0; k < 3; k++) begin
        if (sync2_q[k] != db_q[k]) begin
          if (dbc_q[k] == DB_LAST) begin
            db_q[k]  <= sync2_q[k];
            dbc_q[k] <= '0;
            ev_q[k]  <= db_q[k];  // only a 1->0 flip (press) yields an event
          end else begin
            dbc_q[k] <= dbc_q[k] + 1'b1;
          end
        end else begin
          dbc_q[k] <= '0;
        end
      end
    end
  end

  logic ev_clr, ev_com, ev_ent;
  assign ev_clr = ev_q[2];
  assign ev_com = ev_q[1] & ~ev_q[2];
  assign ev_ent = ev_q[0] & ~ev_q[1] & ~ev_q[2];

  // out_valid/out_ready: a word transfers on any edge where both are high; out_value
  // is frozen while out_valid is high and out_valid falls only after a transfer.
  state_t          state_q, state_d;
  logic [VW-1:0]   val_q, val_d, oval_q, oval_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            ovld_q, ovld_d;

  always_comb begin
    val_d  = val_q;
    cnt_d  = cnt_q;
    oval_d = oval_q;
    ovld_d = ovld_q;
    if (ovld_q && out_ready) ovld_d = 1'b0;
    if (ev_clr) begin
      val_d = '0;
      cnt_d = '0;
    end else if (ev_com) begin
      if (state_q == S_ENTRY) begin
        oval_d = val_q;
        ovld_d = 1'b1;
        val_d  = '0;
        cnt_d  = '0;
      end
    end else if (ev_ent && state_q != S_HOLD) begin
      val_d = (val_q << 4) | VW'(sw_digit);
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 4'd1;
`ifdef HEX_ENTRY_AUTO_COMMIT_EN
      if (cnt_d == CNT_MAX) begin
        oval_d = val_d;
        ovld_d = 1'b1;
        val_d  = '0;
        cnt_d  = '0;
      end
`endif
    end
    if (ovld_d)             state_d = S_HOLD;
    else if (cnt_d != 4'd0) state_d = S_ENTRY;
    else                    state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      val_q   <= '0;
      cnt_q   <= '0;
      oval_q  <= '0;
      ovld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      cnt_q   <= cnt_d;
      oval_q  <= oval_d;
      ovld_q  <= ovld_d;
    end
  end

  assign entry_value = val_q;
  assign entry_count = cnt_q;
  assign out_value   = oval_q;
  assign out_valid   = ovld_q;

endmodule

// File: tb/tb_hex_entry.sv
// tb_hex_entry: directed literal checks plus randomized key traffic against a press-level model.
module tb_hex_entry;
  localparam int DIGITS = 4;
  localparam int DB     = 4;
  localparam int DBW    = 4;
  localparam int VW     = 4 * DIGITS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    sw_digit = 4'h0;
  logic [2:0]    key_n = 3'b111;  // {clear, commit, enter}
  logic          out_ready = 1'b0;
  logic [VW-1:0] entry_value, out_value;
  logic [3:0]    entry_count;
  logic          out_valid;

  int n_cmp = 0;
  int n_fail = 0;

  hex_entry #(.DIGITS(DIGITS), .DB_CYCLES(DB), .DB_W(DBW)) dut (
    .clk(clk), .rst_n(rst_n), .sw_digit(sw_digit),
    .key_enter_n(key_n[0]), .key_commit_n(key_n[1]), .key_clear_n(key_n[2]),
    .entry_value(entry_value), .entry_count(entry_count),
    .out_value(out_value), .out_valid(out_valid), .out_ready(out_ready)
  );

  // clock/reset block
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a press is a low run on the raw pin; it becomes an event once
  // the run reaches DB samples, and the action lands 3 edges after that sample.
  logic [VW-1:0] m_buf, m_out;
  int            m_cnt;
  logic          m_valid;
  int            low_run [3];
  logic [2:0]    pipe [3];

  always @(posedge clk or negedge rst_n) begin : model
    logic clr, com, ent, busy;
    if (!rst_n) begin
      m_buf = '0; m_out = '0; m_cnt = 0; m_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin low_run[k] = 0; pipe[k] = 3'b000; end
    end else begin
      clr  = pipe[2][2];
      com  = pipe[1][2];
      ent  = pipe[0][2];
      busy = m_valid;
      if (m_valid && out_ready) m_valid = 1'b0;
      if (clr) begin
        m_buf = '0; m_cnt = 0;
      end else if (com) begin
        if (!busy && m_cnt > 0) begin
          m_out = m_buf; m_valid = 1'b1; m_buf = '0; m_cnt = 0;
        end
      end else if (ent && !busy) begin
        m_buf = {m_buf[VW-5:0], sw_digit};
        if (m_cnt < DIGITS) m_cnt++;
`ifdef HEX_ENTRY_AUTO_COMMIT_EN
        if (m_cnt == DIGITS) begin
          m_out = m_buf; m_valid = 1'b1; m_buf = '0; m_cnt = 0;
        end
`endif
      end
      for (int k = 0; k < 3; k++) begin
        pipe[k] = {pipe[k][1:0], 1'b0};
        if (key_n[k] == 1'b0) low_run[k]++;
        else low_run[k] = 0;
        if (low_run[k] == DB) pipe[k][0] = 1'b1;
      end
    end
  end

  // scoreboard: every cycle out of reset, DUT outputs against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("entry_value", 32'(entry_value), 32'(m_buf));
      chk("entry_count", 32'(entry_count), 32'(m_cnt));
      chk("out_value",   32'(out_value),   32'(m_out));
      chk("out_valid",   32'(out_valid),   32'(m_valid));
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic press(input logic [2:0] mask, input logic [3:0] d);
    sw_digit = d;
    key_n = ~mask;
    cyc(DB + 2);
    key_n = 3'b111;
    cyc(DB + 4);
  endtask

  task automatic enter_digits(input logic [31:0] digs, input int n);
    for (int i = n - 1; i >= 0; i--) press(3'b001, digs[4*i +: 4]);
  endtask

  int   rem [3];
  logic lowp [3];

  initial begin
    // reset state
    #2;
    chk("rst_entry_value", 32'(entry_value), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    chk("post_rst_count", 32'(entry_count), 32'h0);
    chk("post_rst_out_value", 32'(out_value), 32'h0);

    // glitch shorter than the debounce window
    key_n[0] = 1'b0; cyc(3); key_n = 3'b111; cyc(10);
    chk("glitch_count", 32'(entry_count), 32'h0);

    enter_digits(32'h2AF1, 4);
    chk("2af1_entry", 32'(entry_value), 32'h2AF1);
    chk("2af1_count", 32'(entry_count), 32'd4);
    press(3'b010, 4'h0);
    chk("2af1_out", 32'(out_value), 32'h2AF1);
    chk("2af1_valid", 32'(out_valid), 32'h1);
    chk("2af1_cleared", 32'(entry_value), 32'h0);
    out_ready = 1'b1; cyc(1);
    chk("2af1_xfer", 32'(out_valid), 32'h0);
    out_ready = 1'b0;

`ifndef HEX_ENTRY_AUTO_COMMIT_EN
    enter_digits(32'h12345, 5);
    chk("overflow_entry", 32'(entry_value), 32'h2345);
    chk("overflow_count", 32'(entry_count), 32'd4);
    press(3'b100, 4'h0);
    chk("clear_count", 32'(entry_count), 32'h0);
`else
    enter_digits(32'h1234, 4);
    chk("auto_valid", 32'(out_valid), 32'h1);
    chk("auto_out", 32'(out_value), 32'h1234);
    out_ready = 1'b1; cyc(1); out_ready = 1'b0;
`endif

    // held word with ready low; enter and commit presses must be dropped
    enter_digits(32'hB7, 2);
    chk("b7_entry", 32'(entry_value), 32'h00B7);
    press(3'b010, 4'h0);
    press(3'b001, 4'h5);
    press(3'b010, 4'h0);
    chk("hold_valid", 32'(out_valid), 32'h1);
    chk("hold_out", 32'(out_value), 32'h00B7);
    chk("hold_count", 32'(entry_count), 32'h0);
    out_ready = 1'b1; cyc(1);
    chk("hold_xfer", 32'(out_valid), 32'h0);
    out_ready = 1'b0;

    // clear and enter events in the same cycle
    press(3'b001, 4'h3);
    press(3'b101, 4'h9);
    chk("clr_ent_value", 32'(entry_value), 32'h0);
    chk("clr_ent_count", 32'(entry_count), 32'h0);

    // asynchronous reset while holding a word and mid-debounce
    press(3'b001, 4'h6);
    press(3'b010, 4'h0);
    key_n[0] = 1'b0; cyc(2); #2;
    rst_n = 1'b0; #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'h0);
    chk("async_rst_out_value", 32'(out_value), 32'h0);
    chk("async_rst_count", 32'(entry_count), 32'h0);
    key_n = 3'b111; cyc(2);
    rst_n = 1'b1; cyc(12);
    chk("after_rst_count", 32'(entry_count), 32'h0);
    chk("after_rst_valid", 32'(out_valid), 32'h0);

    // randomized key traffic
    for (int k = 0; k < 3; k++) begin rem[k] = DB + 2 + k; lowp[k] = 1'b0; end
    repeat (4000) begin
      for (int k = 0; k < 3; k++) begin
        if (rem[k] == 0) begin
          lowp[k] = !lowp[k];
          if (lowp[k])
            rem[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DB - 1))
                                                 : int'($urandom_range(DB, DB + 5));
          else
            rem[k] = int'($urandom_range(DB + 2, (k == 2) ? DB + 80 : DB + 25));
        end
        rem[k]--;
        key_n[k] = !lowp[k];
      end
      out_ready = 1'($urandom_range(0, 1));
      sw_digit  = 4'($urandom_range(0, 15));
      cyc(1);
    end
    key_n = 3'b111;
    cyc(DB + 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
